// File: rtl/mem_stage.sv
// Memory access stage: issues aligned loads/stores to the data memory,
// extracts and extends load data, and passes ALU results through to writeback.
module mem_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic            rd_wren,
    input  logic [XLEN-1:0] rs2,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_wren,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_wren_q, wb_wren_d;
    logic            misalign_q, misalign_d;

    logic            is_mem;
    logic            aligned;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_lane;
    logic [XLEN-1:0] ld_val;

    assign is_mem = mem_rd || mem_wr;

    // Access size comes from funct3[1:0]; funct3[2] only selects zero extension.
    always_comb begin
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = rs2;
        unique case (funct3[1:0])
            2'b00: begin
                aligned  = 1'b1;
                st_be    = 4'b0001 << alu_result[1:0];
                st_wdata = {(XLEN/8){rs2[7:0]}};
            end
            2'b01: begin
                aligned  = (alu_result[0] == 1'b0);
                st_be    = 4'b0011 << alu_result[1:0];
                st_wdata = {(XLEN/16){rs2[15:0]}};
            end
            default: begin
                aligned  = (alu_result[1:0] == 2'b00);
                st_be    = 4'b1111;
                st_wdata = rs2;
            end
        endcase
    end

    always_comb begin
        ld_lane = dmem_rdata >> {addr_q[1:0], 3'b000};
        unique case (funct3_q)
            3'b000:  ld_val = {{(XLEN-8){ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_val = {{(XLEN-16){ld_lane[15]}}, ld_lane[15:0]};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_lane[7:0]};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_lane[15:0]};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_valid_d = 1'b0;
        wb_wren_d  = 1'b0;
        misalign_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                        wb_wren_d  = rd_wren && (rd != 5'd0);
                    end else if (!aligned) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        misalign_d = 1'b1;
                    end else begin
                        addr_d   = alu_result;
                        wdata_d  = st_wdata;
                        be_d     = mem_wr ? st_be : 4'b1111;
                        we_d     = mem_wr;
                        funct3_d = funct3;
                        rd_d     = rd;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_ready) begin
                    if (we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        state_d    = S_IDLE;
                    end else if (dmem_rvalid) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ld_val;
                        wb_rd_d    = rd_q;
                        wb_wren_d  = (rd_q != 5'd0);
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_val;
                    wb_rd_d    = rd_q;
                    wb_wren_d  = (rd_q != 5'd0);
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_wren_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_wren_q  <= wb_wren_d;
            misalign_q <= misalign_d;
        end
    end

    // Memory-side controls are gated by state so they drop to zero as soon as reset hits.
    assign ex_ready   = (state_q == S_IDLE);
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = (state_q == S_REQ) && we_q;
    assign dmem_be    = (state_q == S_REQ) ? be_q : 4'b0000;
    assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_wren    = wb_wren_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_result;
    logic        rd_wren;
    logic [31:0] rs2;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wren;
    logic        misalign;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_wb;
    bit          wb_known;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .rd_wren(rd_wren), .rs2(rs2),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_wren(wb_wren), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] data);
        int unsigned sz;
        logic [31:0] v;
        sz = acc_size(f3);
        if (sz == 4) return data;
        v = (data >> (8 * (addr % 4))) % (32'd1 << (8 * sz));
        if (f3[2] == 1'b0 && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            dmem_rvalid = noise ? 1'($urandom) : 1'b0;
            dmem_rdata  = $urandom;
            step();
            check("idle_wb_valid", 32'(wb_valid), 32'd0);
            check("idle_wb_wren", 32'(wb_wren), 32'd0);
            check("idle_misalign", 32'(misalign), 32'd0);
            check("idle_req", 32'(dmem_req), 32'd0);
            check("idle_ready", 32'(ex_ready), 32'd1);
            if (wb_known) check("idle_wb_hold", wb_data, last_wb);
        end
        dmem_rvalid = 1'b0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store
    task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rdi, input bit wren,
                         input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                         input bit same);
        int unsigned sz;
        logic [31:0] exp_be, exp_wd, exp_ld;
        sz = acc_size(f3);
        check("op_ex_ready", 32'(ex_ready), 32'd1);
        ex_valid   = 1'b1;
        alu_result = addr;
        rs2        = data;
        rd         = rdi;
        rd_wren    = wren;
        funct3     = f3;
        mem_rd     = (kind == 1);
        mem_wr     = (kind == 2);
        step();
        ex_valid   = 1'b0;
        alu_result = $urandom;
        rs2        = $urandom;
        rd         = 5'($urandom);
        funct3     = 3'($urandom);
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        if (kind == 0) begin
            check("alu_wb_valid", 32'(wb_valid), 32'd1);
            check("alu_wb_data", wb_data, addr);
            check("alu_wb_rd", 32'(wb_rd), 32'(rdi));
            check("alu_wb_wren", 32'(wb_wren), 32'(wren && rdi != 0));
            check("alu_misalign", 32'(misalign), 32'd0);
            last_wb  = addr;
            wb_known = 1'b1;
            return;
        end

        if (addr % sz != 0) begin
            check("mis_pulse", 32'(misalign), 32'd1);
            check("mis_wb_valid", 32'(wb_valid), 32'd1);
            check("mis_wb_wren", 32'(wb_wren), 32'd0);
            check("mis_req", 32'(dmem_req), 32'd0);
            check("mis_ready", 32'(ex_ready), 32'd1);
            wb_known = 1'b0;
            return;
        end

        exp_be = (sz == 4) ? 32'hF : (((32'd1 << sz) - 1) << (addr % 4));
        if (kind == 1) exp_be = 32'hF;
        if (sz == 1)      exp_wd = (data % 256) * 32'h0101_0101;
        else if (sz == 2) exp_wd = (data % 65536) * 32'h0001_0001;
        else              exp_wd = data;
        exp_ld = model_load(f3, addr, rdata);

        for (int i = 0; i <= rdy_dly; i++) begin
            check("req_valid", 32'(dmem_req), 32'd1);
            check("req_addr", dmem_addr, addr - (addr % 4));
            check("req_be", 32'(dmem_be), exp_be);
            check("req_we", 32'(dmem_we), 32'(kind == 2));
            if (kind == 2) check("req_wdata", dmem_wdata, exp_wd);
            check("req_wb_valid", 32'(wb_valid), 32'd0);
            check("req_ex_ready", 32'(ex_ready), 32'd0);
            dmem_ready  = (i == rdy_dly);
            dmem_rvalid = (kind == 1) && same && (i == rdy_dly);
            dmem_rdata  = dmem_rvalid ? rdata : 32'($urandom);
            step();
        end
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;

        if (kind == 1 && !same) begin
            for (int j = 0; j <= rv_dly; j++) begin
                check("wait_wb_valid", 32'(wb_valid), 32'd0);
                check("wait_req", 32'(dmem_req), 32'd0);
                check("wait_ex_ready", 32'(ex_ready), 32'd0);
                dmem_rvalid = (j == rv_dly);
                dmem_rdata  = dmem_rvalid ? rdata : 32'($urandom);
                step();
            end
            dmem_rvalid = 1'b0;
        end

        check("done_wb_valid", 32'(wb_valid), 32'd1);
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_ex_ready", 32'(ex_ready), 32'd1);
        if (kind == 2) begin
            check("st_wb_wren", 32'(wb_wren), 32'd0);
            wb_known = 1'b0;
        end else begin
            check("ld_wb_data", wb_data, exp_ld);
            check("ld_wb_rd", 32'(wb_rd), 32'(rdi));
            check("ld_wb_wren", 32'(wb_wren), 32'(rdi != 0));
            last_wb  = exp_ld;
            wb_known = 1'b1;
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        int         kind;
        logic [2:0] f3;
        logic [31:0] a;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; rd_wren = 1'b0; rs2 = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0; rd = '0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        wb_known = 1'b1; last_wb = '0;
        #12;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_wren", 32'(wb_wren), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        rst_n = 1'b1;
        step();

        do_op(0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b0);
        idle(1, 1'b0);
        do_op(2, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd3, 1'b0, 3, 0, 32'h0, 1'b0);
        idle(1, 1'b0);
        do_op(1, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 0, 2, 32'h0080_0000, 1'b0);
        do_op(1, 3'b100, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 0, 2, 32'h0080_0000, 1'b0);
        check("lbu_value", wb_data, 32'h0000_0080);
        do_op(1, 3'b010, 32'h0000_0006, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
        idle(1, 1'b0);
        do_op(1, 3'b001, 32'h0000_0002, 32'h0, 5'd9, 1'b1, 1, 0, 32'h8001_0000, 1'b0);
        check("lh_value", wb_data, 32'hFFFF_8001);
        do_op(1, 3'b010, 32'h0000_0040, 32'h0, 5'd0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b1);
        check("lw0_value", wb_data, 32'hDEAD_BEEF);
        idle(2, 1'b1);

        // Reset while waiting for load data: the late rvalid must be dropped.
        ex_valid = 1'b1; alu_result = 32'h200; funct3 = 3'b010; mem_rd = 1'b1; rd = 5'd4;
        step();
        ex_valid = 1'b0; mem_rd = 1'b0;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("rw_in_wait", 32'(ex_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_ex_ready", 32'(ex_ready), 32'd1);
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_be", 32'(dmem_be), 32'd0);
        check("rw_wb_valid", 32'(wb_valid), 32'd0);
        check("rw_wb_data", wb_data, 32'd0);
        step();
        rst_n = 1'b1;
        last_wb = '0; wb_known = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_rvalid = 1'b0;
        check("rw_late_rvalid", 32'(wb_valid), 32'd0);
        check("rw_ready_after", 32'(ex_ready), 32'd1);
        idle(2, 1'b1);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else           f3 = ld_f3[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(f3)) - 1);
            do_op(kind, f3, a, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
            idle($urandom_range(0, 2), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
